// File: rtl/multiply_tokens_if.sv
// Token-stream bundle for multiply_tokens.
//   factor   : tokens emitted per input '1' (shared by all lanes)
//   a        : serial token input, one bit per lane
//   b        : serial token output, one bit per lane
//   busy     : lane has pending output tokens
//   overflow : sticky per-lane overflow flag
// master = token source / consumer side, slave = multiplier side.
interface multiply_tokens_if #(
    parameter int CHANNELS = 2,
    parameter int FACTOR_W = 3
);
    logic [FACTOR_W-1:0] factor;
    logic [CHANNELS-1:0] a;
    logic [CHANNELS-1:0] b;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] overflow;

    modport master (
        output factor,
        output a,
        input  b,
        input  busy,
        input  overflow
    );

    modport slave (
        input  factor,
        input  a,
        output b,
        output busy,
        output overflow
    );
endinterface

// File: rtl/multiply_tokens.sv
// Multi-lane serial token multiplier.
// Every '1' accepted on lane i yields `factor` ones on b[i]: the first in the
// same cycle as the input token, the rest on following cycles.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset (clears pending counts and flags)
//   bus : multiply_tokens_if slave (factor, a in; b, busy, overflow out)
// OVF_MODE 0 kills a lane once it overflows; OVF_MODE 1 clamps the pending
// count at MAX_PENDING and keeps emitting, the flag being status only.
module multiply_tokens #(
    parameter int CHANNELS    = 2,
    parameter int FACTOR_W    = 3,
    parameter int MAX_PENDING = 200,
    parameter int OVF_MODE    = 0
) (
    input  logic             clk,
    input  logic             rst,
    multiply_tokens_if.slave bus
);
    // Wide enough that pending + factor never wraps before the overflow test.
    localparam int PW = $clog2(MAX_PENDING + 2**FACTOR_W + 1);
    localparam logic [PW-1:0] MAX_P = PW'(MAX_PENDING);
    localparam bit KILL = (OVF_MODE == 0);

    logic          factor_nz;
    logic [PW-1:0] factor_ext;

    logic [CHANNELS-1:0] emit_vec;
    logic [CHANNELS-1:0] busy_vec;
    logic [CHANNELS-1:0] ovf_vec;

    assign factor_nz  = (bus.factor != '0);
    assign factor_ext = PW'(bus.factor);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
            logic [PW-1:0] pend_q, pend_d;
            logic          ovf_q, ovf_d;
            logic          tok;
            logic          emit;
            logic [PW-1:0] sum;

            always_comb begin
                tok  = bus.a[gi] & factor_nz;
                emit = (tok | (pend_q != '0)) & ~(ovf_q & KILL);
                // No underflow: emit with pend_q == 0 implies tok, so factor >= 1.
                sum  = pend_q + (tok ? factor_ext : '0) - {{(PW-1){1'b0}}, emit};

                pend_d = sum;
                ovf_d  = ovf_q;
                if (KILL) begin
                    if (ovf_q) begin
                        // Dead lane: hold empty, ignore inputs until reset.
                        pend_d = '0;
                    end else if (sum > MAX_P) begin
                        pend_d = '0;
                        ovf_d  = 1'b1;
                    end
                end else if (sum > MAX_P) begin
                    // Excess tokens are dropped; the lane keeps running.
                    pend_d = MAX_P;
                    ovf_d  = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    pend_q <= '0;
                    ovf_q  <= 1'b0;
                end else begin
                    pend_q <= pend_d;
                    ovf_q  <= ovf_d;
                end
            end

            assign emit_vec[gi] = emit;
            assign busy_vec[gi] = (pend_q != '0);
            assign ovf_vec[gi]  = ovf_q;
        end
    endgenerate

    assign bus.b        = emit_vec;
    assign bus.busy     = busy_vec;
    assign bus.overflow = ovf_vec;
endmodule

// File: tb/tb_multiply_tokens.sv
module tb_multiply_tokens;
    localparam int CH  = 2;
    localparam int FW  = 3;
    localparam int MAXP = 200;

    logic clk;
    logic rst;

    multiply_tokens_if #(.CHANNELS(CH), .FACTOR_W(FW)) bus0 ();
    multiply_tokens_if #(.CHANNELS(CH), .FACTOR_W(FW)) bus1 ();

    multiply_tokens #(.CHANNELS(CH), .FACTOR_W(FW), .MAX_PENDING(MAXP), .OVF_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );
    multiply_tokens #(.CHANNELS(CH), .FACTOR_W(FW), .MAX_PENDING(MAXP), .OVF_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] b;
        logic [CH-1:0] busy;
        logic [CH-1:0] ovf;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad = 0;

    // Reference state per (mode, lane).
    int mp[2][CH];
    bit mo[2][CH];

    // Last values sampled from each DUT (index = mode).
    logic [CH-1:0] last_b[2];
    logic [CH-1:0] last_busy[2];
    logic [CH-1:0] last_ovf[2];

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic void model_out(input int m, input int ln, input logic av, input int fv,
                                      output bit eb, output int n);
        bit tok;
        tok = av && (fv != 0);
        eb  = (tok || mp[m][ln] != 0) && !(mo[m][ln] && m == 0);
        n   = mp[m][ln] + (tok ? fv : 0) - (eb ? 1 : 0);
    endfunction

    task automatic step(input logic [CH-1:0] av, input int fv, input logic rv);
        exp_t e;
        exp_t got;
        bit eb;
        int n;
        bus0.a = av;  bus1.a = av;
        bus0.factor = FW'(fv);  bus1.factor = FW'(fv);
        rst = rv;
        for (int m = 0; m < 2; m++) begin
            e = '0;
            for (int ln = 0; ln < CH; ln++) begin
                model_out(m, ln, av[ln], fv, eb, n);
                e.b[ln]    = eb;
                e.busy[ln] = (mp[m][ln] != 0);
                e.ovf[ln]  = mo[m][ln];
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            e = exp_q.pop_front();
            if (m == 0) got = {bus0.b, bus0.busy, bus0.overflow};
            else        got = {bus1.b, bus1.busy, bus1.overflow};
            check($sformatf("sb_b_m%0d", m),    got.b,    e.b);
            check($sformatf("sb_busy_m%0d", m), got.busy, e.busy);
            check($sformatf("sb_ovf_m%0d", m),  got.ovf,  e.ovf);
            last_b[m]    = got.b;
            last_busy[m] = got.busy;
            last_ovf[m]  = got.ovf;
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            for (int ln = 0; ln < CH; ln++) begin
                model_out(m, ln, av[ln], fv, eb, n);
                if (rv) begin
                    mp[m][ln] = 0;
                    mo[m][ln] = 1'b0;
                end else if (m == 0) begin
                    if (mo[m][ln]) mp[m][ln] = 0;
                    else if (n > MAXP) begin
                        mp[m][ln] = 0;
                        mo[m][ln] = 1'b1;
                    end else mp[m][ln] = n;
                end else begin
                    if (n > MAXP) begin
                        mp[m][ln] = MAXP;
                        mo[m][ln] = 1'b1;
                    end else mp[m][ln] = n;
                end
            end
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [25:0] pat;
        logic [25:0] expb;
        logic [7:0]  f1pat;
        int cnt;
        bit done;

        for (int m = 0; m < 2; m++)
            for (int ln = 0; ln < CH; ln++) begin
                mp[m][ln] = 0;
                mo[m][ln] = 1'b0;
            end
        rst = 1'b1;
        bus0.a = '0; bus1.a = '0;
        bus0.factor = '0; bus1.factor = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        step(2'b00, 0, 1'b1);
        check("rst_b", last_b[0], 0);
        check("rst_busy", last_busy[0], 0);
        check("rst_ovf", last_ovf[1], 0);

        // Reset mid-burst.
        step(2'b01, 2, 1'b0);
        step(2'b01, 2, 1'b0);
        step(2'b01, 2, 1'b0);
        check("burst_busy", last_busy[0][0], 1);
        step(2'b00, 2, 1'b1);
        step(2'b00, 2, 1'b0);
        check("midrst_busy", last_busy[0], 0);
        check("midrst_b", last_b[0], 0);

        // Doubling equivalence, lane 1 idle.
        pat  = 26'b10010011000110100001100100;
        expb = 26'b11011011110111111001111110;
        for (int i = 0; i < 26; i++) begin
            step({1'b0, pat[25-i]}, 2, 1'b0);
            check("dbl_b0", last_b[0][0], expb[25-i]);
            check("dbl_b1", last_b[0][1], 0);
        end

        // Factor 3 single pulse.
        step(2'b01, 3, 1'b0);
        check("f3_b0_t0", last_b[0][0], 1);
        step(2'b00, 3, 1'b0);
        check("f3_b0_t1", last_b[0][0], 1);
        step(2'b00, 3, 1'b0);
        check("f3_b0_t2", last_b[0][0], 1);
        step(2'b00, 3, 1'b0);
        check("f3_b0_t3", last_b[0][0], 0);

        // Factor change mid-burst: pending tokens keep their original count.
        step(2'b01, 3, 1'b0);
        step(2'b00, 1, 1'b0);
        check("fchg_b_t1", last_b[0][0], 1);
        step(2'b00, 1, 1'b0);
        check("fchg_b_t2", last_b[0][0], 1);
        step(2'b00, 1, 1'b0);
        check("fchg_b_t3", last_b[0][0], 0);

        // Factor 1 pass-through.
        f1pat = 8'b10110010;
        for (int i = 0; i < 8; i++) begin
            step({f1pat[i], f1pat[7-i]}, 1, 1'b0);
            check("f1_b0", last_b[0][0], f1pat[7-i]);
            check("f1_b1", last_b[0][1], f1pat[i]);
            check("f1_busy", last_busy[0], 0);
        end

        // Factor 0 drops tokens.
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 0, 1'b0);
            check("f0_b", last_b[0], 0);
            check("f0_busy", last_busy[0], 0);
        end

        // Capacity boundary, lane 1 receives factor-2 pulses throughout.
        step(2'b00, 2, 1'b1);
        for (int k = 0; k < MAXP; k++)
            step({(k % 4 == 0), 1'b1}, 2, 1'b0);
        check("cap200_ovf_m0", last_ovf[0][0], 0);
        check("cap200_ovf_m1", last_ovf[1][0], 0);
        step({1'b0, 1'b1}, 2, 1'b0);
        check("cap201_b_m0", last_b[0][0], 1);
        check("cap201_busy_m0", last_busy[0][0], 1);
        check("cap201_ovf_m0", last_ovf[0][0], 0);
        for (int k = 0; k < 50; k++) begin
            step({(k % 4 == 0), 1'b1}, 2, 1'b0);
            check("dead_b_m0", last_b[0][0], 0);
            check("dead_ovf_m0", last_ovf[0][0], 1);
            check("sat_b_m1", last_b[1][0], 1);
            check("sat_ovf_m1", last_ovf[1][0], 1);
        end
        cnt = 0;
        done = 1'b0;
        for (int j = 0; j < 300 && !done; j++) begin
            step({(j % 4 == 0), 1'b0}, 2, 1'b0);
            if (last_b[1][0]) cnt++;
            else done = 1'b1;
        end
        check("sat_drain_done", done, 1);
        check("sat_drain_len", cnt, MAXP);
        check("ovf_keep_m0", last_ovf[0][0], 1);
        check("ovf_keep_m1", last_ovf[1][0], 1);
        check("lane1_ovf_m0", last_ovf[0][1], 0);
        check("lane1_ovf_m1", last_ovf[1][1], 0);

        // Only reset clears the flag.
        step(2'b00, 2, 1'b1);
        step(2'b00, 2, 1'b0);
        check("clr_ovf_m0", last_ovf[0], 0);
        check("clr_ovf_m1", last_ovf[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
